// File: rtl/cache_definition_pkg.sv
// Shared types for the direct-mapped write-back cache: CPU/memory bus payloads,
// tag-table entries and the controller state encoding.
package cache_definition;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned TAG_W   = 18;
  localparam int unsigned INDEX_W = 10;
  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned WSEL_W  = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
    logic              rw;
    logic              valid;
  } cpu_req_type;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              ready;
  } cpu_result_type;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [BLOCK_W-1:0] data;
    logic               rw;
    logic               valid;
  } mem_req_type;

  typedef struct packed {
    logic [BLOCK_W-1:0] data;
    logic               ready;
  } mem_data_type;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic               we;
  } cache_index_type;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             valid;
    logic             dirty;
  } cache_table_type;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    COMPARE_TAG,
    WRITE_BACK,
    ALLOCATE
  } cache_state_type;

endpackage

// File: rtl/dm_cache_data.sv
// Block data array: combinational read, write on the clock edge when we is set.
module dm_cache_data
  import cache_definition::*;
#(
  parameter int unsigned NUM_ENTRIES = 1024
) (
  input  logic                 clk,
  input  cache_index_type      data_index_i,
  input  logic [BLOCK_W-1:0]   data_write_i,
  output logic [BLOCK_W-1:0]   data_read_o
);

  logic [BLOCK_W-1:0] mem_q [NUM_ENTRIES];

  always_ff @(posedge clk) begin
    if (data_index_i.we) begin
      mem_q[data_index_i.index] <= data_write_i;
    end
  end

  assign data_read_o = mem_q[data_index_i.index];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Write-back, write-allocate controller for the direct-mapped cache. Sweeps the
// tag table invalid after reset, then serves one CPU word request at a time.
module dm_cache_ctrl
  import cache_definition::*;
#(
  parameter int unsigned NUM_ENTRIES   = 1024,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  cpu_req_type        cpu_req,
  output cpu_result_type     cpu_res,
  output mem_req_type        mem_req,
  input  mem_data_type       mem_data,
  output cache_index_type    tag_index,
  output cache_table_type    tag_write,
  input  cache_table_type    tag_read,
  output cache_index_type    data_index,
  output logic [BLOCK_W-1:0] data_write,
  input  logic [BLOCK_W-1:0] data_read,
  output logic               busy
);

  cache_state_type     state_q, state_d;
  logic [INDEX_W-1:0]  init_cnt_q, init_cnt_d;
  logic [TAG_W-1:0]    req_tag_q, req_tag_d;
  logic [INDEX_W-1:0]  req_index_q, req_index_d;
  logic [WSEL_W-1:0]   req_word_q, req_word_d;
  logic [WORD_W-1:0]   req_data_q, req_data_d;
  logic                req_rw_q, req_rw_d;
  logic [ADDR_W-1:0]   victim_addr_q, victim_addr_d;
  logic [BLOCK_W-1:0]  victim_data_q, victim_data_d;
  logic                gap_q, gap_d;

  logic                hit;
  logic [6:0]          word_lsb;
  logic                unused_addr_lsb;

  assign hit             = tag_read.valid && (tag_read.tag == req_tag_q);
  assign word_lsb        = {req_word_q, 5'd0};
  assign unused_addr_lsb = ^cpu_req.addr[1:0];

  // State and request/victim registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= INIT_ON_RESET ? INIT : IDLE;
      init_cnt_q    <= '0;
      req_tag_q     <= '0;
      req_index_q   <= '0;
      req_word_q    <= '0;
      req_data_q    <= '0;
      req_rw_q      <= 1'b0;
      victim_addr_q <= '0;
      victim_data_q <= '0;
      gap_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      req_tag_q     <= req_tag_d;
      req_index_q   <= req_index_d;
      req_word_q    <= req_word_d;
      req_data_q    <= req_data_d;
      req_rw_q      <= req_rw_d;
      victim_addr_q <= victim_addr_d;
      victim_data_q <= victim_data_d;
      gap_q         <= gap_d;
    end
  end

  // Next state; gap_q forces one idle memory cycle between write-back and refill
  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    req_tag_d     = req_tag_q;
    req_index_d   = req_index_q;
    req_word_d    = req_word_q;
    req_data_d    = req_data_q;
    req_rw_d      = req_rw_q;
    victim_addr_d = victim_addr_q;
    victim_data_d = victim_data_q;
    gap_d         = gap_q;
    unique case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + INDEX_W'(1);
        if (init_cnt_q == INDEX_W'(NUM_ENTRIES - 1)) state_d = IDLE;
      end
      IDLE: begin
        if (cpu_req.valid) begin
          req_tag_d   = cpu_req.addr[31:14];
          req_index_d = cpu_req.addr[13:4];
          req_word_d  = cpu_req.addr[3:2];
          req_data_d  = cpu_req.data;
          req_rw_d    = cpu_req.rw;
          state_d     = COMPARE_TAG;
        end
      end
      COMPARE_TAG: begin
        if (hit) begin
          state_d = IDLE;
        end else if (tag_read.valid && tag_read.dirty) begin
          victim_addr_d = {tag_read.tag, req_index_q, 4'b0000};
          victim_data_d = data_read;
          state_d       = WRITE_BACK;
        end else begin
          state_d = ALLOCATE;
        end
      end
      WRITE_BACK: begin
        if (mem_data.ready) begin
          gap_d   = 1'b1;
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (mem_data.ready) begin
          state_d = COMPARE_TAG;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; everything held low while rst is asserted
  always_comb begin
    cpu_res    = '0;
    mem_req    = '0;
    tag_index  = '0;
    tag_write  = '0;
    data_index = '0;
    data_write = '0;
    busy       = (state_q != IDLE);
    unique case (state_q)
      INIT: begin
        tag_index.index = init_cnt_q;
        tag_index.we    = 1'b1;
      end
      COMPARE_TAG: begin
        tag_index.index  = req_index_q;
        data_index.index = req_index_q;
        if (hit) begin
          cpu_res.ready = 1'b1;
          cpu_res.data  = data_read[word_lsb +: WORD_W];
          if (req_rw_q) begin
            data_write                      = data_read;
            data_write[word_lsb +: WORD_W]  = req_data_q;
            data_index.we                   = 1'b1;
            tag_write                       = '{tag: req_tag_q, valid: 1'b1, dirty: 1'b1};
            tag_index.we                    = 1'b1;
          end
        end
      end
      WRITE_BACK: begin
        tag_index.index  = req_index_q;
        data_index.index = req_index_q;
        mem_req          = '{addr: victim_addr_q, data: victim_data_q, rw: 1'b1, valid: 1'b1};
      end
      ALLOCATE: begin
        tag_index.index  = req_index_q;
        data_index.index = req_index_q;
        mem_req.addr     = {req_tag_q, req_index_q, 4'b0000};
        mem_req.valid    = !gap_q;
        if (!gap_q && mem_data.ready) begin
          data_write    = mem_data.data;
          data_index.we = 1'b1;
          tag_write     = '{tag: req_tag_q, valid: 1'b1, dirty: 1'b0};
          tag_index.we  = 1'b1;
        end
      end
      default: ;
    endcase
    if (rst) begin
      cpu_res    = '0;
      mem_req    = '0;
      tag_index  = '0;
      tag_write  = '0;
      data_index = '0;
      data_write = '0;
      busy       = 1'b0;
    end
  end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl with the data array, a tag-table model and a block memory model.
module tb_dm_cache_ctrl;
  import cache_definition::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  cpu_req_type        cpu_req;
  cpu_result_type     cpu_res;
  mem_req_type        mem_req;
  mem_data_type       mem_data;
  cache_index_type    tag_index, data_index;
  cache_table_type    tag_write, tag_read;
  logic [BLOCK_W-1:0] data_write, data_read;
  logic               busy;

  dm_cache_ctrl #(.NUM_ENTRIES(1024), .INIT_ON_RESET(1'b1)) u_dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_res(cpu_res),
    .mem_req(mem_req), .mem_data(mem_data),
    .tag_index(tag_index), .tag_write(tag_write), .tag_read(tag_read),
    .data_index(data_index), .data_write(data_write), .data_read(data_read),
    .busy(busy)
  );

  dm_cache_data #(.NUM_ENTRIES(1024)) u_data (
    .clk(clk), .data_index_i(data_index), .data_write_i(data_write), .data_read_o(data_read)
  );

  // Tag table and main-memory models
  cache_table_type    tag_mem [1024];
  logic [BLOCK_W-1:0] st_data [1024];
  logic [TAG_W-1:0]   st_tag  [1024];
  logic               st_vld  [1024];
  logic               tb_fill = 1'b1;
  int                 mem_lat = 1;
  int                 mem_cnt = 0;
  int                 req_cnt = 0;
  int                 wb_cnt = 0;
  int                 ack_cnt = 0;
  int                 drop_viol = 0;
  logic               prev_valid = 1'b0;
  logic               prev_ack = 1'b0;
  logic [31:0]        alloc_addr = '0;
  logic [31:0]        wb_addr = '0;
  logic [127:0]       wb_data = '0;

  function automatic logic [127:0] mem_default(input logic [31:0] a);
    logic [127:0] b;
    if (a == 32'h0000_1000) b = {32'h4444, 32'h3333, 32'h2222, 32'h1111};
    else for (int w = 0; w < 4; w++) b[w*32 +: 32] = {a[31:4], 2'(w), 2'b01} ^ 32'h5A00_0000;
    return b;
  endfunction

  assign tag_read = tag_mem[tag_index.index];

  always_comb begin
    mem_data.ready = mem_req.valid && (mem_cnt == mem_lat - 1);
    if (st_vld[mem_req.addr[13:4]] && st_tag[mem_req.addr[13:4]] == mem_req.addr[31:14])
      mem_data.data = st_data[mem_req.addr[13:4]];
    else
      mem_data.data = mem_default(mem_req.addr);
  end

  always @(posedge clk) begin
    if (tb_fill) begin
      for (int i = 0; i < 1024; i++) begin
        tag_mem[i] <= '{tag: 18'(i), valid: 1'b1, dirty: 1'b1};
        st_vld[i]  <= 1'b0;
      end
    end else if (tag_index.we) begin
      tag_mem[tag_index.index] <= tag_write;
    end
    mem_cnt <= (mem_req.valid && !mem_data.ready) ? mem_cnt + 1 : 0;
    if (mem_req.valid && mem_data.ready && mem_req.rw) begin
      st_data[mem_req.addr[13:4]] <= mem_req.data;
      st_tag[mem_req.addr[13:4]]  <= mem_req.addr[31:14];
      st_vld[mem_req.addr[13:4]]  <= 1'b1;
      wb_addr <= mem_req.addr;
      wb_data <= mem_req.data;
      wb_cnt  <= wb_cnt + 1;
    end
    prev_valid <= mem_req.valid;
    if (mem_req.valid && !prev_valid) begin
      req_cnt <= req_cnt + 1;
      if (!mem_req.rw) alloc_addr <= mem_req.addr;
    end
    prev_ack <= mem_req.valid && mem_data.ready;
    if (prev_ack && mem_req.valid) drop_viol <= drop_viol + 1;
    if (cpu_res.ready) ack_cnt <= ack_cnt + 1;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic            rw;
    int              lat;
    logic            chk_data;
    logic [31:0]     exp_data;
    int              exp_cyc;
    int              exp_reqs;
    logic [31:0]     exp_alloc;
    logic            chk_tag;
    cache_table_type exp_tag;
    logic [31:0]     exp_wb_addr;
    logic [127:0]    exp_wb_data;
  } vec_t;

  vec_t vecs [11];

  // Apply one CPU request and check latency, data, memory traffic and tag entry
  task automatic run_vec(input int k, input vec_t v);
    int   cyc;
    int   req0;
    logic got;
    logic [31:0] rdata;
    @(negedge clk);
    mem_lat = v.lat;
    req0    = req_cnt;
    cpu_req = '{addr: v.addr, data: v.wdata, rw: v.rw, valid: 1'b1};
    cyc     = 1;
    got     = 1'b0;
    rdata   = '0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (cpu_res.ready) begin
        got   = 1'b1;
        rdata = cpu_res.data;
      end
    end
    cpu_req.valid = 1'b0;
    chk($sformatf("v%0d ack", k), 128'(got), 128'(1'b1));
    chk($sformatf("v%0d cycles", k), 128'(cyc), 128'(v.exp_cyc));
    chk($sformatf("v%0d mem_reqs", k), 128'(req_cnt - req0), 128'(v.exp_reqs));
    if (v.chk_data) chk($sformatf("v%0d rdata", k), 128'(rdata), 128'(v.exp_data));
    if (v.exp_reqs > 0) chk($sformatf("v%0d alloc_addr", k), 128'(alloc_addr), 128'(v.exp_alloc));
    if (v.exp_wb_addr != 0) begin
      chk($sformatf("v%0d wb_addr", k), 128'(wb_addr), 128'(v.exp_wb_addr));
      chk($sformatf("v%0d wb_data", k), wb_data, v.exp_wb_data);
    end
    @(negedge clk);
    if (v.chk_tag) chk($sformatf("v%0d tag_entry", k), 128'(tag_mem[v.addr[13:4]]), 128'(v.exp_tag));
  endtask

  // Count INIT cycles from the current point; flags any CPU ack seen meanwhile
  task automatic count_init(output int n, output logic early_ack);
    n = 0;
    early_ack = 1'b0;
    while (busy && n < 2000) begin
      if (cpu_res.ready) early_ack = 1'b1;
      n++;
      @(negedge clk);
    end
  endtask

  function automatic int dirty_entries();
    int c = 0;
    for (int i = 0; i < 1024; i++) if (tag_mem[i] != '0) c++;
    return c;
  endfunction

  initial begin
    logic [127:0] b5000, bfff0, b3ff0, b2000, wb1000;
    int   n_init;
    logic early;
    logic got;
    logic found;
    int   ack0, wb0;

    b5000  = mem_default(32'h0000_5000);
    bfff0  = mem_default(32'hFFFF_FFF0);
    b3ff0  = mem_default(32'h0000_3FF0);
    b3ff0[63:32] = 32'h1234_5678;
    b2000  = mem_default(32'h0000_2000);
    wb1000 = {32'h4444, 32'hDEAD_BEEF, 32'h2222, 32'h1111};

    //           addr          wdata         rw   lat chk exp_data        cyc reqs alloc          chk tag                           wb_addr        wb_data
    vecs[0]  = '{32'h0000_1004, 32'h0,        1'b0, 5, 1'b1, 32'h2222,      8, 1, 32'h0000_1000, 1'b1, '{18'h0, 1'b1, 1'b0},     32'h0, 128'h0};
    vecs[1]  = '{32'h0000_1008, 32'hDEAD_BEEF, 1'b1, 5, 1'b0, 32'h0,        2, 0, 32'h0,         1'b1, '{18'h0, 1'b1, 1'b1},     32'h0, 128'h0};
    vecs[2]  = '{32'h0000_1008, 32'h0,        1'b0, 5, 1'b1, 32'hDEAD_BEEF, 2, 0, 32'h0,         1'b1, '{18'h0, 1'b1, 1'b1},     32'h0, 128'h0};
    vecs[3]  = '{32'h0000_5008, 32'h0,        1'b0, 5, 1'b1, b5000[95:64],  14, 2, 32'h0000_5000, 1'b1, '{18'h1, 1'b1, 1'b0},    32'h0000_1000, wb1000};
    vecs[4]  = '{32'h0000_1000, 32'h0,        1'b0, 1, 1'b1, 32'h1111,      4, 1, 32'h0000_1000, 1'b1, '{18'h0, 1'b1, 1'b0},     32'h0, 128'h0};
    vecs[5]  = '{32'h0000_1008, 32'h0,        1'b0, 1, 1'b1, 32'hDEAD_BEEF, 2, 0, 32'h0,         1'b0, '{18'h0, 1'b0, 1'b0},     32'h0, 128'h0};
    vecs[6]  = '{32'h0000_3FF4, 32'h1234_5678, 1'b1, 1, 1'b0, 32'h0,        4, 1, 32'h0000_3FF0, 1'b1, '{18'h0, 1'b1, 1'b1},     32'h0, 128'h0};
    vecs[7]  = '{32'h0000_3FF4, 32'h0,        1'b0, 1, 1'b1, 32'h1234_5678, 2, 0, 32'h0,         1'b0, '{18'h0, 1'b0, 1'b0},     32'h0, 128'h0};
    vecs[8]  = '{32'hFFFF_FFFC, 32'h0,        1'b0, 1, 1'b1, bfff0[127:96], 6, 2, 32'hFFFF_FFF0, 1'b1, '{18'h3FFFF, 1'b1, 1'b0}, 32'h0000_3FF0, b3ff0};
    vecs[9]  = '{32'h0000_3FF4, 32'h0,        1'b0, 3, 1'b1, 32'h1234_5678, 6, 1, 32'h0000_3FF0, 1'b1, '{18'h0, 1'b1, 1'b0},     32'h0, 128'h0};
    vecs[10] = '{32'h0000_1008, 32'hCAFE_F00D, 1'b1, 1, 1'b0, 32'h0,        2, 0, 32'h0,         1'b1, '{18'h0, 1'b1, 1'b1},     32'h0, 128'h0};

    // Reset, with a read held pending through the whole sweep
    rst     = 1'b1;
    cpu_req = '{addr: 32'h0000_2000, data: 32'h0, rw: 1'b0, valid: 1'b1};
    @(negedge clk);
    tb_fill = 1'b0;
    chk("reset outputs", 128'({busy, cpu_res.ready, mem_req.valid, tag_index.we, data_index.we}), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("init first write", 128'({busy, tag_index.we, tag_index.index}), 128'({1'b1, 1'b1, 10'd0}));
    count_init(n_init, early);
    chk("init busy cycles", 128'(n_init), 128'(1024));
    chk("ack during init", 128'(early), 128'(1'b0));
    chk("entries not cleared", 128'(dirty_entries()), 128'(0));

    mem_lat = 2;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (cpu_res.ready) begin
        got = 1'b1;
        chk("post-init rdata", 128'(cpu_res.data), 128'(b2000[31:0]));
      end
    end
    cpu_req.valid = 1'b0;
    chk("post-init ack", 128'(got), 128'(1'b1));

    for (int k = 0; k < 11; k++) run_vec(k, vecs[k]);
    chk("valid held after ready", 128'(drop_viol), 128'(0));

    // Reset in the middle of a write-back of the dirty line at index 0x100
    @(negedge clk);
    mem_lat = 20;
    ack0    = ack_cnt;
    wb0     = wb_cnt;
    cpu_req = '{addr: 32'h0000_5000, data: 32'h0, rw: 1'b0, valid: 1'b1};
    found   = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (mem_req.valid && mem_req.rw) found = 1'b1;
    end
    chk("wb started", 128'(found), 128'(1'b1));
    chk("wb addr live", 128'(mem_req.addr), 128'(32'h0000_1000));
    @(negedge clk);
    rst = 1'b1;
    cpu_req.valid = 1'b0;
    @(negedge clk);
    chk("mem valid after rst", 128'(mem_req.valid), 128'(1'b0));
    rst = 1'b0;
    #1;
    chk("init restarts", 128'({busy, tag_index.we, tag_index.index}), 128'({1'b1, 1'b1, 10'd0}));
    count_init(n_init, early);
    chk("reinit busy cycles", 128'(n_init), 128'(1024));
    chk("no ack after rst", 128'(ack_cnt - ack0), 128'(0));
    chk("no wb completion", 128'(wb_cnt - wb0), 128'(0));
    chk("entries cleared again", 128'(dirty_entries()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
Write-back, write-allocate controller for the direct-mapped cache. It sequences the 1024-entry tag table (tag+valid+dirty) and the companion 128-bit block data array. It services one CPU word request at a time and generates block-sized refill and write-back transactions to main memory. After reset it clears every valid bit before it accepts any request.

Parameters:
NUM_ENTRIES, 1024, table depth; must match the tag table and data array depth (index width 10).
INIT_ON_RESET, 1, 1 = sweep all entries to invalid after reset; 0 = skip the sweep (simulation speed-up only).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cpu_req  in  cpu_req_type (32 addr + 32 data + rw + valid = 66)  CPU request; rw=1 write; held until cpu_res.ready
cpu_res  out  cpu_result_type (32 data + ready = 33)  read data and 1-cycle done pulse
mem_req  out  mem_req_type (32 addr + 128 data + rw + valid = 162)  block request to memory
mem_data  in  mem_data_type (128 data + ready = 129)  memory response; ready = transaction complete
tag_index  out  cache_index_type (10 index + we = 11)  tag table index and write enable
tag_write  out  cache_table_type (18 tag + valid + dirty = 20)  tag table write data
tag_read  in  cache_table_type (20)  tag table combinational read
data_index  out  cache_index_type (11)  data array index and write enable
data_write  out  128  data array write block
data_read  in  128  data array combinational read
busy  out  1  high in every state except IDLE

Behaviour:
- Address split: tag=addr[31:14], index=addr[13:4], word=addr[3:2], addr[1:0] ignored.
- Reset: state=INIT when INIT_ON_RESET=1, else IDLE; sweep counter=0; all outputs 0 (cpu_res.ready=0, mem_req.valid=0, both we=0). Reset in any state aborts the current operation with no further table or memory writes. Memory sees mem_req.valid drop in the cycle after rst is sampled.
- INIT: writes {tag=0, valid=0, dirty=0} at counter index, one entry per cycle. Goes to IDLE after index 1023 (1024 cycles). cpu_req is ignored.
- IDLE: when cpu_req.valid=1, registers addr/data/rw and goes to COMPARE_TAG. No table writes.
- COMPARE_TAG: drives the registered index; hit = tag_read.valid && tag_read.tag==req tag.
  - Read hit: cpu_res.data = selected 32-bit word of data_read; cpu_res.ready=1 for this cycle; goes to IDLE.
  - Write hit: merges the word into data_read and writes it (data we=1). Writes tag {req tag, 1, dirty=1}. cpu_res.ready=1; goes to IDLE.
  - Miss with a victim that is invalid or clean: goes to ALLOCATE.
  - Miss with a valid, dirty victim: registers the victim address {tag_read.tag, index, 4'b0} and data_read; goes to WRITE_BACK.
- WRITE_BACK: mem_req = {victim addr, victim block, rw=1, valid=1}, held stable. When mem_data.ready=1, goes to ALLOCATE.
- ALLOCATE: mem_req = {req tag, index, 4'b0; rw=0; valid=1}. When mem_data.ready=1, writes mem_data.data to the data array and tag {req tag, 1, 0}; goes to COMPARE_TAG, which then hits.
- mem_data.ready is accepted in the same cycle mem_req.valid rises. mem_req.valid deasserts in the cycle after ready; the next request starts one cycle later or more.
- mem_data.ready outside WRITE_BACK/ALLOCATE is ignored. cpu_req changes while busy are ignored.
- Latency: hit = 2 cycles from valid to ready. A clean miss adds the memory latency + 1 cycle; a dirty miss also adds the write-back latency + 1 cycle.
- Tag and data writes to the same index happen in the same cycle; there is never a write to two different indices in one cycle.

Decomposition:
- Package cache_definition: TAG_W=18, INDEX_W=10, BLOCK_W=128, cpu_req_type, cpu_result_type, mem_req_type, mem_data_type, cache_index_type, cache_table_type, and the state enum {INIT, IDLE, COMPARE_TAG, WRITE_BACK, ALLOCATE}.
- Data array: separate module dm_cache_data (128-bit entries, combinational read, registered write). The controller itself is a single FSM module with no sub-modules.

Test Plan:
- Reset with INIT_ON_RESET=1 -> busy=1 for 1024 cycles, every tag entry has valid=0, then busy=0; a cpu_req asserted during INIT is not acknowledged until after INIT.
- Read 0x0000_1004 on a cold cache -> ALLOCATE, mem_req addr 0x0000_1000 rw=0; memory returns 0x4444_3333_2222_1111 (128-bit, word 1=0x2222) after 5 cycles -> cpu_res.data=0x2222, entry 0x100 tag=0 valid=1 dirty=0.
- Write 0xDEAD_BEEF to 0x0000_1008 after the previous fill -> hit, ready 2 cycles after valid, entry dirty=1, word 2 updated, no mem_req.
- Read 0x0000_5008 (same index, new tag) -> WRITE_BACK addr 0x0000_1000 with the dirty block (word 2=0xDEAD_BEEF), then ALLOCATE addr 0x0000_5000, then hit.
- Memory ready in the same cycle as mem_req.valid -> transition occurs and valid drops the next cycle, with no duplicate request.
- rst asserted mid-WRITE_BACK -> mem_req.valid=0 the next cycle, INIT restarts, no cpu_res.ready pulse.
